// File: rtl/alu_stack_driver.sv
// Operand stack that feeds an external combinational ALU: PUSH/POP act in one cycle,
// ALU commands spend one ISSUE cycle driving the ALU and write the result back.
module alu_stack_driver #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_code,
    input  logic [3:0]               cmd_op,
    input  logic [31:0]              cmd_data,
    output logic [31:0]              alu_x,
    output logic [31:0]              alu_y,
    output logic [11:0]              alu_opcode,
    input  logic [31:0]              alu_z,
    input  logic [3:0]               alu_flags,
    output logic [31:0]              tos,
    output logic [$clog2(DEPTH):0]   depth,
    output logic [3:0]               flags,
    output logic [2:0]               err
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    localparam logic [1:0] CMD_PUSH = 2'd0;
    localparam logic [1:0] CMD_POP  = 2'd1;
    localparam logic [1:0] CMD_ALU  = 2'd2;
    localparam logic [1:0] CMD_RSVD = 2'd3;

    typedef enum logic {IDLE, ISSUE} state_t;

    // ADD, SUB, AND, OR, XOR consume two entries; everything else consumes one.
    function automatic logic is_binary(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd8, 4'd9, 4'd10: is_binary = 1'b1;
            default:                       is_binary = 1'b0;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic [3:0]        flags_q, flags_d;
    logic [2:0]        err_q,   err_d;
    logic [3:0]        op_q,    op_d;

    logic [31:0]       stack_mem [DEPTH];
    logic              wr_en;
    logic [AW-1:0]     wr_idx;
    logic [31:0]       wr_data;
    logic [AW-1:0]     top_idx;
    logic [AW-1:0]     below_idx;

    assign top_idx   = AW'(depth_q - DW'(1));
    assign below_idx = AW'(depth_q - DW'(2));

    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        flags_d = flags_q;
        err_d   = '0;
        op_d    = op_q;
        wr_en   = 1'b0;
        wr_idx  = depth_q[AW-1:0];
        wr_data = cmd_data;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    // Illegal is decided before any operand-count check.
                    if (cmd_code == CMD_RSVD || (cmd_code == CMD_ALU && cmd_op > 4'd11)) begin
                        err_d[2] = 1'b1;
                    end else begin
                        case (cmd_code)
                            CMD_PUSH: begin
                                if (depth_q == DW'(DEPTH)) begin
                                    err_d[0] = 1'b1;
                                end else begin
                                    wr_en   = 1'b1;
                                    depth_d = depth_q + DW'(1);
                                end
                            end
                            CMD_POP: begin
                                if (depth_q == '0) err_d[1] = 1'b1;
                                else               depth_d = depth_q - DW'(1);
                            end
                            default: begin
                                if (depth_q < (is_binary(cmd_op) ? DW'(2) : DW'(1))) begin
                                    err_d[1] = 1'b1;
                                end else begin
                                    op_d    = cmd_op;
                                    state_d = ISSUE;
                                end
                            end
                        endcase
                    end
                end
            end
            ISSUE: begin
                wr_en   = 1'b1;
                wr_data = alu_z;
                flags_d = alu_flags;
                state_d = IDLE;
                if (is_binary(op_q)) begin
                    wr_idx  = below_idx;
                    depth_d = depth_q - DW'(1);
                end else begin
                    wr_idx  = top_idx;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            depth_q <= '0;
            flags_q <= '0;
            err_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            flags_q <= flags_d;
            err_q   <= err_d;
            op_q    <= op_d;
        end
    end

    // Storage is not cleared by reset; gating on rst_n drops an in-flight ALU result.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            stack_mem[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        alu_x      = '0;
        alu_y      = '0;
        alu_opcode = '0;
        if (state_q == ISSUE) begin
            alu_opcode = 12'd1 << op_q;
            if (is_binary(op_q)) begin
                alu_x = stack_mem[below_idx];
                alu_y = stack_mem[top_idx];
            end else begin
                alu_x = stack_mem[top_idx];
            end
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign tos       = (depth_q == '0) ? 32'd0 : stack_mem[top_idx];
    assign depth     = depth_q;
    assign flags     = flags_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_stack_driver.sv
// Scoreboard bench for alu_stack_driver with a behavioural ALU attached to its ALU port.
module tb_alu_stack_driver;

    localparam int DEPTH = 16;
    localparam int DW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_code;
    logic [3:0]    cmd_op;
    logic [31:0]   cmd_data;
    logic [31:0]   alu_x, alu_y, alu_z;
    logic [11:0]   alu_opcode;
    logic [3:0]    alu_flags;
    logic [31:0]   tos;
    logic [DW-1:0] depth;
    logic [3:0]    flags;
    logic [2:0]    err;

    alu_stack_driver #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_code(cmd_code), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .alu_x(alu_x), .alu_y(alu_y), .alu_opcode(alu_opcode),
        .alu_z(alu_z), .alu_flags(alu_flags),
        .tos(tos), .depth(depth), .flags(flags), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: flags are {CF, OF, SF, ZF}.
    logic [32:0] wide;
    logic [31:0] z;
    logic        cf, of;
    always_comb begin
        wide = '0;
        z    = '0;
        cf   = 1'b0;
        of   = 1'b0;
        case (alu_opcode)
            12'h001: begin
                wide = {1'b0, alu_x} + {1'b0, alu_y};
                z    = wide[31:0];
                cf   = wide[32];
                of   = (alu_x[31] == alu_y[31]) && (z[31] != alu_x[31]);
            end
            12'h002: begin
                z  = alu_x - alu_y;
                cf = alu_x < alu_y;
                of = (alu_x[31] != alu_y[31]) && (z[31] != alu_x[31]);
            end
            12'h004: z = alu_x + 32'd1;
            12'h008: z = alu_x - 32'd1;
            12'h010: z = 32'd0 - alu_x;
            12'h020: begin z = alu_x << 1; cf = alu_x[31]; end
            12'h040: begin z = alu_x >> 1; cf = alu_x[0];  end
            12'h080: begin z = $unsigned($signed(alu_x) >>> 1); cf = alu_x[0]; end
            12'h100: z = alu_x & alu_y;
            12'h200: z = alu_x | alu_y;
            12'h400: z = alu_x ^ alu_y;
            12'h800: z = ~alu_x;
            default: z = '0;
        endcase
        alu_z     = z;
        alu_flags = {cf, of, z[31], (z == 32'd0)};
    end

    typedef struct {
        logic [31:0]   tos;
        logic [DW-1:0] dep;
        logic [3:0]    fl;
        logic [2:0]    err;
    } st_t;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [11:0] op;
    } iss_t;

    st_t  st_q[$];
    iss_t iss_q[$];

    // Expectations published by the stimulus alongside each command.
    logic [31:0]   exp_tos, exp_x, exp_y;
    logic [DW-1:0] exp_dep;
    logic [3:0]    exp_fl;
    logic [2:0]    exp_err;
    logic [11:0]   exp_op;
    logic          exp_state, exp_issue;
    logic          done;

    logic rst_at_edge = 1'b0;
    logic acc_at_edge = 1'b0;

    always @(posedge clk) begin
        rst_at_edge <= !rst_n;
        acc_at_edge <= rst_n && cmd_valid && cmd_ready;
        if (rst_n && cmd_valid && cmd_ready) begin
            if (exp_state) st_q.push_back('{exp_tos, exp_dep, exp_fl, exp_err});
            if (exp_issue) iss_q.push_back('{exp_x, exp_y, exp_op});
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    initial begin
        int  st_rd   = 0;
        int  iss_rd  = 0;
        bit  pending = 0;
        bit  was_low = 0;
        forever begin
            @(negedge clk);
            if (rst_at_edge)      pending = 0;
            else if (acc_at_edge) pending = 1;
            if (!rst_n) begin
                if (rst_at_edge) begin
                    chk("rst_depth",  32'(depth), 32'd0);
                    chk("rst_tos",    tos, 32'd0);
                    chk("rst_flags",  32'(flags), 32'd0);
                    chk("rst_err",    32'(err), 32'd0);
                    chk("rst_opcode", 32'(alu_opcode), 32'd0);
                end
            end else begin
                if (was_low) chk("ready_after_rst", 32'(cmd_ready), 32'd1);
                if (alu_opcode != 12'd0) begin
                    if (iss_rd < iss_q.size()) begin
                        chk("issue_x",      alu_x, iss_q[iss_rd].x);
                        chk("issue_y",      alu_y, iss_q[iss_rd].y);
                        chk("issue_opcode", 32'(alu_opcode), 32'(iss_q[iss_rd].op));
                        iss_rd++;
                    end else begin
                        chk("unexpected_issue_opcode", 32'(alu_opcode), 32'd0);
                    end
                end else begin
                    chk("idle_alu_xy", alu_x | alu_y, 32'd0);
                end
                if (pending && cmd_ready) begin
                    pending = 0;
                    if (st_rd < st_q.size()) begin
                        chk("tos",   tos, st_q[st_rd].tos);
                        chk("depth", 32'(depth), 32'(st_q[st_rd].dep));
                        chk("flags", 32'(flags), 32'(st_q[st_rd].fl));
                        chk("err",   32'(err), 32'(st_q[st_rd].err));
                        st_rd++;
                    end else begin
                        chk("unexpected_completion", 32'd1, 32'd0);
                    end
                end else begin
                    chk("err_quiet", 32'(err), 32'd0);
                end
            end
            was_low = !rst_n;
            if (done) begin
                chk("state_queue_drained", 32'(st_rd), 32'(st_q.size()));
                chk("issue_queue_drained", 32'(iss_rd), 32'(iss_q.size()));
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    task automatic send(input logic [1:0] code, input logic [3:0] op, input logic [31:0] data,
                        input logic [31:0] etos, input int edep, input logic [3:0] efl,
                        input logic [2:0] eerr, input logic est, input logic eiss,
                        input logic [31:0] ex, input logic [31:0] ey, input logic [11:0] eop);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            $display("FAIL cmd_ready_wait: got 0 expected 1 within 20 cycles");
            $fatal(1, "stalled");
        end
        cmd_valid = 1'b1;
        cmd_code  = code;
        cmd_op    = op;
        cmd_data  = data;
        exp_tos   = etos;
        exp_dep   = DW'(edep);
        exp_fl    = efl;
        exp_err   = eerr;
        exp_state = est;
        exp_issue = eiss;
        exp_x     = ex;
        exp_y     = ey;
        exp_op    = eop;
        @(posedge clk);
    endtask

    task automatic push(input logic [31:0] d, input int edep, input logic [3:0] efl);
        send(2'd0, 4'd0, d, d, edep, efl, 3'b000, 1'b1, 1'b0, 32'd0, 32'd0, 12'd0);
    endtask

    task automatic pop(input logic [31:0] etos, input int edep, input logic [3:0] efl);
        send(2'd1, 4'd0, 32'd0, etos, edep, efl, 3'b000, 1'b1, 1'b0, 32'd0, 32'd0, 12'd0);
    endtask

    task automatic alu(input logic [3:0] op, input logic [31:0] ex, input logic [31:0] ey,
                       input logic [11:0] eop, input logic [31:0] etos, input int edep,
                       input logic [3:0] efl);
        send(2'd2, op, 32'd0, etos, edep, efl, 3'b000, 1'b1, 1'b1, ex, ey, eop);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_code = '0; cmd_op = '0; cmd_data = '0;
        exp_tos = '0; exp_dep = '0; exp_fl = '0; exp_err = '0; exp_state = 1'b0;
        exp_issue = 1'b0; exp_x = '0; exp_y = '0; exp_op = '0; done = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        push(32'd5, 1, 4'h0);
        push(32'd3, 2, 4'h0);
        alu(4'd1, 32'd5, 32'd3, 12'h002, 32'd2, 1, 4'h0);
        pop(32'd0, 0, 4'h0);
        push(32'd7, 1, 4'h0);
        push(32'd7, 2, 4'h0);
        alu(4'd1, 32'd7, 32'd7, 12'h002, 32'd0, 1, 4'h1);
        pop(32'd0, 0, 4'h1);
        push(32'h8000_0000, 1, 4'h1);
        alu(4'd7, 32'h8000_0000, 32'd0, 12'h080, 32'hC000_0000, 1, 4'h2);
        // Underflow and illegal commands leave everything but err alone.
        send(2'd2, 4'd0,  32'd0, 32'hC000_0000, 1, 4'h2, 3'b010, 1'b1, 1'b0, 32'd0, 32'd0, 12'd0);
        send(2'd2, 4'd12, 32'd0, 32'hC000_0000, 1, 4'h2, 3'b100, 1'b1, 1'b0, 32'd0, 32'd0, 12'd0);
        send(2'd3, 4'd0,  32'd9, 32'hC000_0000, 1, 4'h2, 3'b100, 1'b1, 1'b0, 32'd0, 32'd0, 12'd0);
        pop(32'd0, 0, 4'h2);
        send(2'd1, 4'd0,  32'd0, 32'd0, 0, 4'h2, 3'b010, 1'b1, 1'b0, 32'd0, 32'd0, 12'd0);
        push(32'h0000_00FF, 1, 4'h2);
        push(32'h0000_0F0F, 2, 4'h2);
        alu(4'd8,  32'h0000_00FF, 32'h0000_0F0F, 12'h100, 32'h0000_000F, 1, 4'h0);
        alu(4'd11, 32'h0000_000F, 32'd0, 12'h800, 32'hFFFF_FFF0, 1, 4'h2);
        alu(4'd2,  32'hFFFF_FFF0, 32'd0, 12'h004, 32'hFFFF_FFF1, 1, 4'h2);
        push(32'h10, 2, 4'h2);
        alu(4'd0,  32'hFFFF_FFF1, 32'h10, 12'h001, 32'd1, 1, 4'h8);
        alu(4'd5,  32'd1, 32'd0, 12'h020, 32'd2, 1, 4'h0);
        pop(32'd0, 0, 4'h0);

        for (int i = 0; i < DEPTH; i++) push(32'd100 + 32'(i), i + 1, 4'h0);
        send(2'd0, 4'd0, 32'd999, 32'd100 + 32'(DEPTH - 1), DEPTH, 4'h0, 3'b001,
             1'b1, 1'b0, 32'd0, 32'd0, 12'd0);

        // Reset lands while the ADD is in ISSUE; its result must never appear.
        send(2'd2, 4'd0, 32'd0, 32'd0, 0, 4'h0, 3'b000, 1'b0, 1'b1,
             32'd100 + 32'(DEPTH - 2), 32'd100 + 32'(DEPTH - 1), 12'h001);
        @(negedge clk);
        #1 rst_n = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        push(32'd42, 1, 4'h0);

        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 done = 1'b1;
    end

endmodule
